mem_write_buffer: RTL and testbench

//   Line-granular write buffer between the cache top (L1 + victim cache memory mux) and main memory.

---
 rtl/mem_write_buffer.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_write_buffer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_buffer.sv
// Line write buffer between cache and memory. Write-backs are acked early and drained in the background; reads forward from the youngest buffered copy. The optional WB_COALESCE_EN build merges a write into a matching entry.
// Latency: write ack and read hit arrive 1 cycle after accept, a read miss 1 cycle after mem_resp_valid. Backpressure: a write stalls while full; the memory side holds its request until mem_req_ready.
module mem_write_buffer #(
  parameter int  ADDR_WIDTH = 32,
  parameter int  LINE_BYTES = 16,
  parameter int  DEPTH      = 4,
  localparam int LW         = LINE_BYTES * 8,
  localparam int OFF        = $clog2(LINE_BYTES),
  localparam int PW         = $clog2(DEPTH),
  localparam int LA         = ADDR_WIDTH - OFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  up_req_valid,
  input  logic                  up_req_rw,
  input  logic [ADDR_WIDTH-1:0] up_req_addr,
  input  logic [LW-1:0]         up_req_wdata,
  output logic                  up_resp_valid,
  output logic [LW-1:0]         up_resp_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_rw,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [LW-1:0]         mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [LW-1:0]         mem_resp_rdata,
  output logic [PW:0]           wb_count
);

  typedef enum logic [1:0] {U_IDLE, U_MISS, U_RESP} u_state_e;
  typedef enum logic [1:0] {M_IDLE, M_WR, M_RD} m_state_e;

  u_state_e      u_state_q, u_state_d;
  m_state_e      m_state_q, m_state_d;
  logic          rearm_q, rearm_d;
  logic          rd_pend_q, rd_pend_d;
  logic [LA-1:0] rd_addr_q, rd_addr_d;
  logic [LW-1:0] resp_dat_q, resp_dat_d;
  logic          mreq_vld_q, mreq_vld_d;
  logic [PW:0]   head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0] ent_vld_q, ent_vld_d;
  logic [LA-1:0] ent_addr_q [DEPTH];
  logic [LA-1:0] ent_addr_d [DEPTH];
  logic [LW-1:0] ent_dat_q [DEPTH];
  logic [LW-1:0] ent_dat_d [DEPTH];

  logic [LA-1:0] req_line;
  logic [PW-1:0] head_idx, tail_idx, slot, hit_idx;
  logic [PW:0]   count;
  logic          full, empty, hit, enq, coal, deq, rd_done, rd_issue;
  logic          unused_offset;

  assign req_line      = up_req_addr[ADDR_WIDTH-1:OFF];
  assign unused_offset = ^up_req_addr[OFF-1:0];
  assign head_idx      = head_q[PW-1:0];
  assign tail_idx      = tail_q[PW-1:0];
  assign count         = tail_q - head_q;
  assign full          = (count == (PW+1)'(DEPTH));
  assign empty         = (head_q == tail_q);
  // A response is only meaningful once the request has been handed over.
  assign deq      = (m_state_q == M_WR) && !mreq_vld_q && mem_resp_valid;
  assign rd_done  = (m_state_q == M_RD) && !mreq_vld_q && mem_resp_valid;
  assign rd_issue = (m_state_q == M_IDLE) && rd_pend_q;

  // Scan oldest to youngest so the last match found is the youngest.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    slot    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head_idx + PW'(i);
      if (ent_vld_q[slot] && (ent_addr_q[slot] == req_line)) begin
        hit     = 1'b1;
        hit_idx = slot;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u_state_q  <= U_IDLE;
      m_state_q  <= M_IDLE;
      rearm_q    <= 1'b1;
      rd_pend_q  <= 1'b0;
      rd_addr_q  <= '0;
      resp_dat_q <= '0;
      mreq_vld_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      ent_vld_q  <= '0;
      ent_addr_q <= '{default: '0};
      ent_dat_q  <= '{default: '0};
    end else begin
      u_state_q  <= u_state_d;
      m_state_q  <= m_state_d;
      rearm_q    <= rearm_d;
      rd_pend_q  <= rd_pend_d;
      rd_addr_q  <= rd_addr_d;
      resp_dat_q <= resp_dat_d;
      mreq_vld_q <= mreq_vld_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      ent_vld_q  <= ent_vld_d;
      ent_addr_q <= ent_addr_d;
      ent_dat_q  <= ent_dat_d;
    end
  end

  // Upstream FSM next state.
  always_comb begin
    u_state_d  = u_state_q;
    rearm_d    = up_req_valid ? rearm_q : 1'b1;
    rd_pend_d  = rd_pend_q && !rd_issue;
    rd_addr_d  = rd_addr_q;
    resp_dat_d = resp_dat_q;
    enq        = 1'b0;
    coal       = 1'b0;
    case (u_state_q)
      U_IDLE: begin
        if (up_req_valid && rearm_q) begin
          if (up_req_rw) begin
`ifdef WB_COALESCE_EN
            // The in-flight head must not change under the memory, so it gets a fresh entry.
            if (hit && !((hit_idx == head_idx) && (m_state_q == M_WR))) begin
              coal = 1'b1;
            end else if (!full || deq) begin
              enq = 1'b1;
            end
`else
            if (!full || deq) begin
              enq = 1'b1;
            end
`endif
            if (coal || enq) begin
              u_state_d  = U_RESP;
              resp_dat_d = '0;
              rearm_d    = 1'b0;
            end
          end else begin
            rearm_d = 1'b0;
            if (hit) begin
              resp_dat_d = ent_dat_q[hit_idx];
              u_state_d  = U_RESP;
            end else begin
              rd_pend_d = 1'b1;
              rd_addr_d = req_line;
              u_state_d = U_MISS;
            end
          end
        end
      end
      U_MISS: begin
        if (rd_done) begin
          resp_dat_d = mem_resp_rdata;
          u_state_d  = U_RESP;
        end
      end
      default: u_state_d = U_IDLE;
    endcase
  end

  // Memory FSM next state; a pending miss goes ahead of draining.
  always_comb begin
    m_state_d  = m_state_q;
    mreq_vld_d = mreq_vld_q;
    case (m_state_q)
      M_IDLE: begin
        if (rd_pend_q) begin
          m_state_d  = M_RD;
          mreq_vld_d = 1'b1;
        end else if (!empty) begin
          m_state_d  = M_WR;
          mreq_vld_d = 1'b1;
        end
      end
      default: begin
        if (mreq_vld_q) begin
          if (mem_req_ready) mreq_vld_d = 1'b0;
        end else if (mem_resp_valid) begin
          m_state_d = M_IDLE;
        end
      end
    endcase
  end

  // Entry storage; when full, enqueue reuses the slot freed by the same-cycle dequeue.
  always_comb begin
    ent_vld_d  = ent_vld_q;
    ent_addr_d = ent_addr_q;
    ent_dat_d  = ent_dat_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (deq) begin
      ent_vld_d[head_idx] = 1'b0;
      head_d              = head_q + (PW+1)'(1);
    end
    if (enq) begin
      ent_vld_d[tail_idx]  = 1'b1;
      ent_addr_d[tail_idx] = req_line;
      ent_dat_d[tail_idx]  = up_req_wdata;
      tail_d               = tail_q + (PW+1)'(1);
    end
    if (coal) begin
      ent_dat_d[hit_idx] = up_req_wdata;
    end
  end

  // Drain address/data come straight from the head entry, which is frozen while in M_WR.
  always_comb begin
    up_resp_valid = (u_state_q == U_RESP);
    up_resp_rdata = (u_state_q == U_RESP) ? resp_dat_q : '0;
    mem_req_valid = mreq_vld_q;
    mem_req_rw    = (m_state_q == M_WR);
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    if (m_state_q == M_WR) begin
      mem_req_addr  = {ent_addr_q[head_idx], {OFF{1'b0}}};
      mem_req_wdata = ent_dat_q[head_idx];
    end else if (m_state_q == M_RD) begin
      mem_req_addr = {rd_addr_q, {OFF{1'b0}}};
    end
    wb_count = count;
  end

endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed bench for mem_write_buffer: early write acks, forwarding, full stall, miss priority, reset and coalescing.
module tb_mem_write_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         up_req_valid, up_req_rw;
  logic [31:0]  up_req_addr;
  logic [127:0] up_req_wdata;
  logic         up_resp_valid;
  logic [127:0] up_resp_rdata;
  logic         mem_req_valid, mem_req_ready, mem_req_rw;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_wdata;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_rdata;
  logic [2:0]   wb_count;

  int n_checks = 0;
  int n_errors = 0;

`ifdef WB_COALESCE_EN
  localparam int COAL = 1;
`else
  localparam int COAL = 0;
`endif

  localparam logic [127:0] D1 = 128'h1111_0001_1111_0002_1111_0003_1111_0004;
  localparam logic [127:0] D2 = 128'h2222_0001_2222_0002_2222_0003_2222_0004;
  localparam logic [127:0] DA = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
  localparam logic [127:0] DB = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;
  localparam logic [127:0] DZ = 128'hCAFE_0000_0000_0000_0000_0000_0000_00FF;
  localparam logic [127:0] DY = 128'h0000_0000_BEEF_0000_0000_0000_0000_0077;
  localparam logic [127:0] R1 = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;

  mem_write_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .up_req_valid   (up_req_valid),
    .up_req_rw      (up_req_rw),
    .up_req_addr    (up_req_addr),
    .up_req_wdata   (up_req_wdata),
    .up_resp_valid  (up_resp_valid),
    .up_resp_rdata  (up_resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_rw     (mem_req_rw),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .wb_count       (wb_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [127:0] d);
    int lat;
    up_req_valid = 1'b1; up_req_rw = 1'b1; up_req_addr = a; up_req_wdata = d;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!up_resp_valid && lat < 20);
    chk({tag, "_ack_lat"}, 128'(lat), 128'd1);
    chk({tag, "_ack_rdata"}, up_resp_rdata, 128'd0);
    up_req_valid = 1'b0;
    step();
  endtask

  task automatic do_read_hit(input string tag, input logic [31:0] a, input logic [127:0] d);
    up_req_valid = 1'b1; up_req_rw = 1'b0; up_req_addr = a;
    step();
    chk({tag, "_vld"}, 128'(up_resp_valid), 128'd1);
    chk({tag, "_rdata"}, up_resp_rdata, d);
    up_req_valid = 1'b0;
    step();
  endtask

  task automatic drain_one(input string tag, input logic [31:0] a, input logic [127:0] d);
    int w;
    w = 0;
    while (!mem_req_valid && w < 20) begin
      step();
      w++;
    end
    chk({tag, "_req_vld"}, 128'(mem_req_valid), 128'd1);
    chk({tag, "_rw"}, 128'(mem_req_rw), 128'd1);
    chk({tag, "_addr"}, 128'(mem_req_addr), 128'(a));
    chk({tag, "_wdata"}, mem_req_wdata, d);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    up_req_valid = 1'b0; up_req_rw = 1'b0; up_req_addr = '0; up_req_wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    step(); step();
    chk("rst_resp_vld", 128'(up_resp_valid), 128'd0);
    chk("rst_resp_rdata", up_resp_rdata, 128'd0);
    chk("rst_mem_vld", 128'(mem_req_valid), 128'd0);
    chk("rst_mem_addr", 128'(mem_req_addr), 128'd0);
    chk("rst_count", 128'(wb_count), 128'd0);
    rst = 1'b0;
    step();

    // Single write-back drained with memory always ready.
    mem_req_ready = 1'b1;
    up_req_valid = 1'b1; up_req_rw = 1'b1; up_req_addr = 32'h100; up_req_wdata = D1;
    step();
    chk("t1_ack", 128'(up_resp_valid), 128'd1);
    chk("t1_ack_rdata", up_resp_rdata, 128'd0);
    chk("t1_count1", 128'(wb_count), 128'd1);
    chk("t1_no_req_yet", 128'(mem_req_valid), 128'd0);
    up_req_valid = 1'b0;
    step();
    chk("t1_ack_done", 128'(up_resp_valid), 128'd0);
    chk("t1_req_vld", 128'(mem_req_valid), 128'd1);
    chk("t1_req_rw", 128'(mem_req_rw), 128'd1);
    chk("t1_req_addr", 128'(mem_req_addr), 128'h100);
    chk("t1_req_wdata", mem_req_wdata, D1);
    step();
    chk("t1_req_dropped", 128'(mem_req_valid), 128'd0);
    chk("t1_count_wait", 128'(wb_count), 128'd1);
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    chk("t1_count0", 128'(wb_count), 128'd0);

    // Read forwarded from a buffered write; held request is not re-accepted.
    do_write("t2_w", 32'h100, D2);
    chk("t2_drain_started", 128'(mem_req_valid), 128'd1);
    up_req_valid = 1'b1; up_req_rw = 1'b0; up_req_addr = 32'h104;
    step();
    chk("t2_hit_vld", 128'(up_resp_valid), 128'd1);
    chk("t2_hit_rdata", up_resp_rdata, D2);
    chk("t2_no_mem_read", 128'(mem_req_rw), 128'd1);
    step();
    chk("t2_rdata_cleared", up_resp_rdata, 128'd0);
    step();
    chk("t2_held_no_reaccept", 128'(up_resp_valid), 128'd0);
    up_req_valid = 1'b0;
    step();
    drain_one("t2_d", 32'h100, D2);
    chk("t2_count0", 128'(wb_count), 128'd0);

    // Fill to DEPTH; the fifth write waits for the head to retire.
    do_write("t3_w0", 32'h00, 128'h0A);
    do_write("t3_w1", 32'h10, 128'h1A);
    do_write("t3_w2", 32'h20, 128'h2A);
    do_write("t3_w3", 32'h30, 128'h3A);
    chk("t3_full_count", 128'(wb_count), 128'd4);
    up_req_valid = 1'b1; up_req_rw = 1'b1; up_req_addr = 32'h40; up_req_wdata = 128'h4A;
    step(); step(); step();
    chk("t3_full_stall", 128'(up_resp_valid), 128'd0);
    chk("t3_full_head", 128'(mem_req_addr), 128'h0);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("t3_stall_after_hs", 128'(up_resp_valid), 128'd0);
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    up_req_valid = 1'b0;
    chk("t3_ack_on_free", 128'(up_resp_valid), 128'd1);
    chk("t3_count_same", 128'(wb_count), 128'd4);
    step();
    drain_one("t3_d1", 32'h10, 128'h1A);
    drain_one("t3_d2", 32'h20, 128'h2A);
    drain_one("t3_d3", 32'h30, 128'h3A);
    drain_one("t3_d4", 32'h40, 128'h4A);
    chk("t3_count0", 128'(wb_count), 128'd0);

    // A pending miss goes to memory ahead of the remaining drains.
    do_write("t4_w0", 32'h500, 128'h50);
    do_write("t4_w1", 32'h510, 128'h51);
    do_write("t4_w2", 32'h520, 128'h52);
    up_req_valid = 1'b1; up_req_rw = 1'b0; up_req_addr = 32'h200;
    step(); step();
    chk("t4_miss_wait", 128'(up_resp_valid), 128'd0);
    chk("t4_head_inflight", 128'(mem_req_addr), 128'h500);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    chk("t4_count2", 128'(wb_count), 128'd2);
    step();
    chk("t4_rd_vld", 128'(mem_req_valid), 128'd1);
    chk("t4_rd_rw", 128'(mem_req_rw), 128'd0);
    chk("t4_rd_addr", 128'(mem_req_addr), 128'h200);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("t4_no_early_resp", 128'(up_resp_valid), 128'd0);
    mem_resp_valid = 1'b1; mem_resp_rdata = R1;
    step();
    mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    chk("t4_miss_vld", 128'(up_resp_valid), 128'd1);
    chk("t4_miss_rdata", up_resp_rdata, R1);
    up_req_valid = 1'b0;
    step();
    chk("t4_pulse_end", 128'(up_resp_valid), 128'd0);
    drain_one("t4_d1", 32'h510, 128'h51);
    drain_one("t4_d2", 32'h520, 128'h52);
    chk("t4_count0", 128'(wb_count), 128'd0);

    // Same-line writes: merged when coalescing, except into the in-flight head.
    do_write("t6_wz", 32'h000, DZ);
    do_write("t6_wa", 32'h300, DA);
    do_write("t6_wb", 32'h300, DB);
    chk("t6_count_ab", 128'(wb_count), 128'(3 - COAL));
    do_read_hit("t6_rd300", 32'h308, DB);
    do_write("t6_wy", 32'h000, DY);
    chk("t6_count_y", 128'(wb_count), 128'(4 - COAL));
    do_read_hit("t6_rd0", 32'h000, DY);
    drain_one("t6_dz", 32'h000, DZ);
`ifndef WB_COALESCE_EN
    drain_one("t6_da", 32'h300, DA);
`endif
    drain_one("t6_db", 32'h300, DB);
    drain_one("t6_dy", 32'h000, DY);
    chk("t6_count0", 128'(wb_count), 128'd0);

    // Reset while a drain is waiting for its response.
    do_write("t5_w0", 32'h700, 128'h70);
    do_write("t5_w1", 32'h710, 128'h71);
    do_write("t5_w2", 32'h720, 128'h72);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_count", 128'(wb_count), 128'd0);
    chk("t5_rst_mem_vld", 128'(mem_req_valid), 128'd0);
    chk("t5_rst_mem_rw", 128'(mem_req_rw), 128'd0);
    chk("t5_rst_mem_addr", 128'(mem_req_addr), 128'd0);
    chk("t5_rst_mem_wdata", mem_req_wdata, 128'd0);
    chk("t5_rst_resp", 128'(up_resp_valid), 128'd0);
    step();
    rst = 1'b0;
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    step();
    chk("t5_stale_resp_count", 128'(wb_count), 128'd0);
    chk("t5_stale_resp_mem", 128'(mem_req_valid), 128'd0);
    do_write("t5_w8", 32'h800, 128'h80);
    drain_one("t5_d8", 32'h800, 128'h80);
    chk("t5_count0", 128'(wb_count), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
